// File: rtl/fir_mac_param.sv
// Time-multiplexed FIR filter: one shared multiplier, one tap per cycle.
// A sample is accepted in IDLE, TAP multiply-accumulates follow in MAC,
// and OUT rounds, shifts and saturates the sum into out_data.
module fir_mac_param #(
   parameter int WORD_SIZE = 10,
   parameter int COEF_W    = 6,
   parameter int TAP       = 21,
   parameter int OUT_W     = 12,
   parameter int OUT_SHIFT = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WORD_SIZE-1:0] in_data,
   input  logic                      coef_we,
   input  logic [$clog2(TAP)-1:0]    coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   output logic                      out_valid,
   output logic signed [OUT_W-1:0]   out_data
);

   localparam int CW  = $clog2(TAP);
   localparam int PW  = WORD_SIZE + COEF_W;
   localparam int AW  = WORD_SIZE + COEF_W + CW;
   // Result width: one bit above the accumulator for the rounding add,
   // and never narrower than the output plus a sign bit for the clamp.
   localparam int RW  = (AW + 1 > OUT_W + 1) ? AW + 1 : OUT_W + 1;
   localparam int RND = (2 ** OUT_SHIFT) / 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   logic [1:0]                  state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic signed [AW-1:0]        acc_q, acc_d;
   logic                        ov_q, ov_d;
   logic signed [OUT_W-1:0]     od_q, od_d;
   logic signed [WORD_SIZE-1:0] x_q [TAP];
   logic signed [COEF_W-1:0]    c_q [TAP];

   logic signed [PW-1:0]        prod;
   logic signed [RW-1:0]        sum_ext;
   logic signed [RW-1:0]        shf;
   logic signed [RW-1:0]        max_v, min_v;
   logic                        accept;
   logic                        coef_ok;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign accept    = in_valid && (state_q == IDLE);
   assign coef_ok   = coef_we && (state_q == IDLE) &&
                      ({1'b0, coef_addr} < (CW + 1)'(TAP));

   // Shared multiplier, then round, shift and saturate for the OUT state
   always_comb begin
      prod    = c_q[cnt_q] * x_q[cnt_q];
      sum_ext = $signed({{(RW - AW){acc_q[AW-1]}}, acc_q}) + RW'(RND);
      shf     = sum_ext >>> OUT_SHIFT;
      max_v   = $signed({{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
      min_v   = $signed({{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}});
   end

   // Next-state logic for the IDLE -> MAC -> OUT sequence
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ov_d    = 1'b0;
      od_d    = od_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         MAC: begin
            acc_d = acc_q + $signed({{(AW - PW){prod[PW-1]}}, prod});
            if (cnt_q == CW'(TAP - 1)) begin
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         OUT: begin
            if (shf > max_v) begin
               od_d = max_v[OUT_W-1:0];
            end else if (shf < min_v) begin
               od_d = min_v[OUT_W-1:0];
            end else begin
               od_d = shf[OUT_W-1:0];
            end
            ov_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

   // Sample delay line, shifted on each accepted sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < TAP; k++) x_q[k] <= '0;
      end else if (accept) begin
         for (int unsigned k = TAP - 1; k > 0; k--) x_q[k] <= x_q[k-1];
         x_q[0] <= in_data;
      end
   end

   // Coefficient register file, writable only while idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < TAP; k++) c_q[k] <= '0;
      end else if (coef_ok) begin
         c_q[coef_addr] <= coef_data;
      end
   end

endmodule

// File: tb/tb_fir_mac_param.sv
// Bench for fir_mac_param: two instances (OUT_SHIFT 0 and 1) share all
// stimulus and are compared against a sum-of-products reference model.
module tb_fir_mac_param;

   localparam int WS   = 10;
   localparam int CWD  = 6;
   localparam int TAP  = 21;
   localparam int OW   = 12;
   localparam int AWID = $clog2(TAP);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic signed [WS-1:0]  in_data;
   logic                  coef_we;
   logic [AWID-1:0]       coef_addr;
   logic signed [CWD-1:0] coef_data;
   logic                  rdy0, ov0, rdy1, ov1;
   logic signed [OW-1:0]  od0, od1;

   always #5 clk = ~clk;

   fir_mac_param #(.WORD_SIZE(WS), .COEF_W(CWD), .TAP(TAP), .OUT_W(OW), .OUT_SHIFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(ov0), .out_data(od0));

   fir_mac_param #(.WORD_SIZE(WS), .COEF_W(CWD), .TAP(TAP), .OUT_W(OW), .OUT_SHIFT(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(ov1), .out_data(od1));

   int checks = 0;
   int errors = 0;
   int c_m [TAP];
   int x_m [TAP];
   int c_tab [TAP] = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, 21, 18, 10, 1, -4, -4, -1, 2, 3, 1, -1};

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint mac_sum();
      longint s = 0;
      for (int k = 0; k < TAP; k++) s += longint'(c_m[k]) * longint'(x_m[k]);
      return s;
   endfunction

   function automatic longint shape(input longint s, input int sh);
      longint r;
      longint hi = (longint'(1) << (OW - 1)) - 1;
      longint lo = -(longint'(1) << (OW - 1));
      r = (s + ((longint'(1) << sh) / 2)) >>> sh;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   function automatic void model_push(input int v);
      for (int k = TAP - 1; k > 0; k--) x_m[k] = x_m[k-1];
      x_m[0] = v;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < TAP; k++) begin
         c_m[k] = 0;
         x_m[k] = 0;
      end
   endfunction

   task automatic write_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = a[AWID-1:0];
      coef_data = v[CWD-1:0];
      tick();
      coef_we = 1'b0;
      if (a < TAP) c_m[a] = v;
   endtask

   // One sample through the filter; optional write on the accept edge
   // and optional (ignored) write in the middle of the MAC pass.
   task automatic send(input int v, input bit w_now, input int wa, input int wd, input bit w_mac);
      int n;
      bit hi_seen, chg;
      longint s, e0, e1;
      logic signed [OW-1:0] p0, p1;
      n = 0;
      while (!rdy0 && n < 50) begin
         tick();
         n++;
      end
      check("ready_before_send", rdy0, 1);
      in_valid  = 1'b1;
      in_data   = v[WS-1:0];
      coef_we   = w_now;
      coef_addr = wa[AWID-1:0];
      coef_data = wd[CWD-1:0];
      tick();
      in_valid = 1'b0;
      coef_we  = 1'b0;
      in_data  = WS'($urandom);
      if (w_now && wa < TAP) c_m[wa] = wd;
      model_push(v);
      s  = mac_sum();
      e0 = shape(s, 0);
      e1 = shape(s, 1);
      p0 = od0;
      p1 = od1;
      hi_seen = 1'b0;
      chg = 1'b0;
      n = 0;
      while (!ov0 && n < TAP + 10) begin
         if (w_mac && n == 5) begin
            coef_we   = 1'b1;
            coef_addr = wa[AWID-1:0];
            coef_data = ~wd[CWD-1:0];
         end else begin
            coef_we = 1'b0;
         end
         tick();
         n++;
         if (!ov0) begin
            if (rdy0) hi_seen = 1'b1;
            if (od0 != p0 || od1 != p1) chg = 1'b1;
         end
      end
      coef_we = 1'b0;
      check("latency", n, TAP + 1);
      check("busy_ready", hi_seen, 0);
      check("hold_out", chg, 0);
      check("out_shift0", od0, e0);
      check("out_shift1", od1, e1);
      check("ov_both", ov1, 1);
      check("ready_at_out", rdy0, 1);
      tick();
      check("ov_one_cycle", ov0, 0);
   endtask

   // in_valid held high: back-to-back acceptances at the maximum rate
   task automatic stream(input int v, input int nsamp);
      int cyc, prev, acc_c, got;
      bit r;
      longint s, e0, e1;
      e0 = 0;
      e1 = 0;
      cyc = 0;
      prev = -1;
      acc_c = 0;
      got = 0;
      in_valid = 1'b1;
      in_data  = v[WS-1:0];
      while (got < nsamp && cyc < nsamp * (TAP + 2) + 50) begin
         r = rdy0;
         tick();
         cyc++;
         if (r) begin
            if (prev >= 0) check("accept_gap", cyc - prev, TAP + 2);
            prev  = cyc;
            acc_c = cyc;
            model_push(v);
            s  = mac_sum();
            e0 = shape(s, 0);
            e1 = shape(s, 1);
         end
         if (ov0) begin
            got++;
            check("stream_latency", cyc - acc_c, TAP + 1);
            check("stream_out0", od0, e0);
            check("stream_out1", od1, e1);
         end
      end
      in_valid = 1'b0;
      check("stream_done", got, nsamp);
      tick();
   endtask

   initial begin
      bit bad;
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      model_clear();
      #3;
      check("rst_ready", rdy0, 1);
      check("rst_ov", ov0, 0);
      check("rst_out", od0, 0);
      #19 rst = 1'b1;
      tick();

      // Impulse response with the reference coefficient set
      for (int k = 0; k < TAP; k++) write_coef(k, c_tab[k]);
      for (int i = 0; i < TAP; i++) begin
         send((i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0);
         check("impulse_tap", od0, c_tab[i]);
      end

      // Writes during MAC and to an out-of-range index must be ignored
      send(0, 1'b0, 3, 7, 1'b1);
      write_coef(TAP, 5);
      for (int i = 0; i < TAP; i++) begin
         send((i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0);
         check("impulse_again", od0, c_tab[i]);
      end

      // Saturation at both rails
      stream(511, TAP + 2);
      check("sat_pos", od0, 2047);
      stream(-512, TAP + 2);
      check("sat_neg", od0, -2048);

      // Random coefficients, samples and writes
      for (int k = 0; k < TAP; k++) write_coef(k, int'($urandom_range(0, 63)) - 32);
      for (int i = 0; i < 40; i++) begin
         send(int'($urandom_range(0, 1023)) - 512,
              ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 63)) - 32,
              ($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of a MAC pass
      in_valid = 1'b1;
      in_data  = WS'(1);
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      check("mid_busy", rdy0, 0);
      #2 rst = 1'b0;
      #1;
      check("mrst_ready", rdy0, 1);
      check("mrst_ov", ov0, 0);
      check("mrst_out0", od0, 0);
      check("mrst_out1", od1, 0);
      model_clear();
      bad = 1'b0;
      repeat (TAP + 4) begin
         tick();
         if (ov0 || ov1) bad = 1'b1;
      end
      @(negedge clk) rst = 1'b1;
      bad = bad | ov0;
      repeat (TAP + 4) begin
         tick();
         if (ov0 || ov1) bad = 1'b1;
      end
      check("no_pulse_after_reset", bad, 0);
      send(1, 1'b0, 0, 0, 1'b0);
      check("cleared_coefs", od0, 0);

      // Round-half-up with OUT_SHIFT = 1
      write_coef(0, 3);
      send(1, 1'b0, 0, 0, 1'b0);
      check("round_up", od1, 2);
      write_coef(0, -1);
      send(1, 1'b0, 0, 0, 1'b0);
      check("round_neg_half", od1, 0);

      // Same-edge write and accept uses the new coefficient
      send(2, 1'b1, 0, 5, 1'b0);
      check("same_edge_write", od0, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fir_mac_param.md
FIR_MAC_PARAM -- requirements
Module: fir_mac_param

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 10: signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 6: signed coefficient width.
REQ-003 SHALL have parameter TAP, default 21: filter length, legal range 2..64.
REQ-004 SHALL have parameter OUT_W, default 12: signed output width.
REQ-005 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied before output, legal range 0..16.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-010 SHALL have port in_data, input, WORD_SIZE bits: signed sample.
REQ-011 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-012 SHALL have port coef_addr, input, clog2(TAP) bits: coefficient index k.
REQ-013 SHALL have port coef_data, input, COEF_W bits: signed coefficient value.
REQ-014 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a valid out_data.
REQ-015 SHALL have port out_data, output, OUT_W bits: signed filtered sample.

Function
REQ-016 SHALL hold a TAP-entry coefficient register file c[0..TAP-1] and a TAP-entry sample delay line x[0..TAP-1], with x[0] the newest sample.
REQ-017 SHALL implement a FSM with states IDLE, MAC and OUT, and drive in_ready = (state == IDLE).
REQ-018 SHALL accept a sample on a rising edge where in_valid && in_ready; on that edge it shifts x (x[k] <= x[k-1], x[0] <= in_data), clears the accumulator and counter, and goes to MAC.
REQ-019 SHALL perform one multiply-accumulate per cycle in MAC (acc += c[cnt]*x[cnt], cnt = 0..TAP-1) through a single shared multiplier, and go to OUT after the cnt = TAP-1 term.
REQ-020 SHALL size the accumulator at WORD_SIZE+COEF_W+clog2(TAP) bits, signed, so that no intermediate overflow occurs.
REQ-021 SHALL, in OUT, compute r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (no rounding term when OUT_SHIFT = 0; round-half-up), saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it into out_data, pulse out_valid for exactly one cycle, and return to IDLE.
REQ-022 SHALL assert out_valid at the (TAP+1)th rising edge after the acceptance edge, which gives a throughput of one sample per TAP+2 cycles; in_ready is high during the out_valid cycle.
REQ-023 SHALL hold out_data stable between out_valid pulses.
REQ-024 SHALL perform a coefficient write when coef_we is high in IDLE and coef_addr < TAP, with effect from the following edge.
REQ-025 SHALL ignore a coefficient write when the block is not in IDLE or when coef_addr >= TAP.
REQ-026 SHALL, when a sample accept and a coefficient write occur on the same edge, perform both; the MAC pass that follows uses the new coefficient.
REQ-027 SHALL not consume or queue samples offered while in_ready is low; in_data is don't-care whenever in_valid is low.

Reset
REQ-028 SHALL, on rst low, immediately clear the FSM to IDLE and set cnt, acc, all x[k], all c[k], out_data and out_valid to 0; in_ready reads 1 while reset is held low.
REQ-029 SHALL abandon any in-flight computation on reset; no out_valid pulse is produced for it.
REQ-030 SHALL release reset cleanly on a rising edge of rst, and SHALL accept its first sample no earlier than the first clk edge after release.

Verification
REQ-031 Impulse, defaults: load c = {-1,1,3,2,-1,-4,-4,1,10,18,21,18,10,1,-4,-4,-1,2,3,1,-1}; feed 1 followed by 20 zeros -> the 21 out_data values equal c[0..20] in order, each out_valid exactly 22 edges after its acceptance edge.
REQ-032 Saturation, coefficients as in REQ-031: feed 511 continuously -> out_data converges to +2047 (true sum 36281); feed -512 continuously -> out_data converges to -2048.
REQ-033 Rounding, OUT_SHIFT = 1: c[0] = 3, other c = 0, input 1 -> out_data = 2; then c[0] = -1, input 1 -> out_data = 0.
REQ-034 Handshake: hold in_valid high throughout -> acceptances exactly TAP+2 cycles apart, and in_ready is low during MAC and OUT.
REQ-035 Coefficient write attempted during MAC, and a write with coef_addr = TAP: both are ignored, so a following impulse reproduces the unchanged c.
REQ-036 Reset: assert rst low at the 10th MAC cycle -> out_valid stays 0, all outputs read 0, and the next impulse after release yields all-zero output because the coefficients were cleared.
